// File: rtl/nibble_serial_adder_arbiter.sv
// Two-requester round-robin front end sharing one 4-bit ripple adder slice.
// Each accepted add/subtract runs LSB nibble first through a registered carry.
module nibble_serial_adder_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic             req0_Cin,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic             req1_Cin,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_Sum,
    output logic             resp_Cout,
    output logic             resp_Ovf,
    output logic             resp_id,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NW-1:0] LAST = NW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic             carry_q, carry_d;
    logic [NW-1:0]    nib_q, nib_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic             id_q, id_d;

    logic             grant0, grant1, sel, sel_sub;
    logic [3:0]       a_nib, b_nib, s_nib;
    logic [4:0]       c;

    // Readies are suppressed while reset is held so nothing is accepted then.
    always_comb begin
        grant0 = (state_q == IDLE) && !rst && req0_valid && (!req1_valid || rr_last_q);
        grant1 = (state_q == IDLE) && !rst && req1_valid && (!req0_valid || !rr_last_q);
    end

    always_comb begin
        a_nib = a_q[{nib_q, 2'b00} +: 4];
        b_nib = b_q[{nib_q, 2'b00} +: 4];
        c     = '0;
        s_nib = '0;
        c[0]  = carry_q;
        for (int i = 0; i < 4; i++) begin
            s_nib[i] = a_nib[i] ^ b_nib[i] ^ c[i];
            c[i+1]   = (a_nib[i] & b_nib[i]) | (c[i] & (a_nib[i] ^ b_nib[i]));
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        carry_d   = carry_q;
        nib_d     = nib_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        id_d      = id_q;
        sel       = grant1;
        sel_sub   = sel ? req1_sub : req0_sub;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d       = sel ? req1_A : req0_A;
                    b_d       = sel_sub ? ~(sel ? req1_B : req0_B) : (sel ? req1_B : req0_B);
                    carry_d   = sel_sub ? 1'b1 : (sel ? req1_Cin : req0_Cin);
                    id_d      = sel;
                    rr_last_d = sel;
                    nib_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                sum_d[{nib_q, 2'b00} +: 4] = s_nib;
                carry_d = c[4];
                if (nib_q == LAST) begin
                    // Carry into vs. out of the sign bit flags signed overflow.
                    ovf_d   = c[3] ^ c[4];
                    state_d = DONE;
                end else begin
                    nib_d = nib_q + 1'b1;
                end
            end
            DONE: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            carry_q   <= 1'b0;
            nib_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            carry_q   <= carry_d;
            nib_q     <= nib_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            id_q      <= id_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign resp_valid = (state_q == DONE);
    assign resp_Sum   = sum_q;
    assign resp_Cout  = carry_q;
    assign resp_Ovf   = ovf_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/nibble_serial_adder_arbiter.md
Name: nibble_serial_adder_arbiter

Overview:
- Shares one 4-bit ripple adder slice between two requesters.
- Arbitrates between them round-robin and runs each accepted WIDTH-bit add or subtract one nibble per cycle, LSB nibble first, through a registered carry.
- Returns the result on a valid/ready response channel tagged with the requester id.
- Sits between requesting datapath units and the shared adder resource; trades latency for area.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4 is derived.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_A  input  WIDTH  operand A from requester 0.
- req0_B  input  WIDTH  operand B from requester 0.
- req0_Cin  input  1  carry input for add; ignored when sub=1.
- req0_sub  input  1  1 = A - B, 0 = A + B + Cin.
- req1_valid, req1_ready, req1_A, req1_B, req1_Cin, req1_sub  same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_Sum  output  WIDTH  result.
- resp_Cout  output  1  carry out of the top nibble. For sub: 1 = no borrow.
- resp_Ovf  output  1  signed two's-complement overflow.
- resp_id  output  1  requester that issued the operation.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; rr_last = 1, so requester 0 wins first.
  - carry, nibble index, operand and result registers = 0.
  - resp_valid = 0, busy = 0, req*_ready = 0.
  - Any in-flight operation is dropped; no response is produced for it.
- States and transitions:
  - IDLE:
    - Only one valid: grant it.
    - Both valid: grant the requester != rr_last.
    - req_ready for the granted requester is combinational: asserted only in IDLE while its valid is high.
    - Never assert both readies in the same cycle.
    - On handshake:
      - Capture A.
      - Capture B, inverted if sub=1.
      - Initial carry = sub ? 1 : Cin.
      - Record id; set rr_last = id; nibble index = 0.
      - Go to RUN.
  - RUN, one nibble per cycle:
    - Sum nibble[i] = A[i] ^ B'[i] ^ carry, computed bitwise with ripple inside the nibble.
    - Carry register takes the nibble carry-out.
    - Ovf computed on the top nibble from the carry into and out of bit WIDTH-1.
    - After nibble NIBBLES-1: go to DONE.
  - DONE:
    - resp_valid = 1. resp_Sum, resp_Cout, resp_Ovf and resp_id are held stable until resp_ready.
    - On resp_valid & resp_ready: go to IDLE next cycle.
    - No new request is accepted in the DONE cycle.
- Latency:
  - Request handshake at cycle T → resp_valid first high at T+NIBBLES+1 (T+5 for WIDTH=16).
  - Minimum issue interval is NIBBLES+2 cycles.
- Operands are captured at handshake; requester input changes after acceptance have no effect.
- Simultaneous events:
  - Both requesters valid across back-to-back operations → strict alternation.
  - A requester that drops valid before being granted loses nothing, since no state is kept for it.
- Wrap-around: Sum is modulo 2^WIDTH; the overflow bit appears only on resp_Cout.
- A sustained resp_ready=0 stalls indefinitely in DONE; both req_ready stay 0 (backpressure).

Test Plan (WIDTH=16):
1. Basic add with latency check: req0 A=0x00FF, B=0x0001, Cin=0, sub=0 → resp_Sum=0x0100, Cout=0, Ovf=0, id=0; resp_valid exactly 5 cycles after the handshake; busy high for the whole operation.
2. Full carry propagation: A=0xFFFF, B=0x0000, Cin=1 → Sum=0x0000, Cout=1, Ovf=0. Then A=0x7FFF, B=0x0001, Cin=0 → Sum=0x8000, Cout=0, Ovf=1.
3. Subtract:
   - A=0x0003, B=0x0005, sub=1, Cin=1 (must be ignored) → Sum=0xFFFE, Cout=0.
   - A=0x8000, B=0x0001, sub=1 → Sum=0x7FFF, Cout=1, Ovf=1.
4. Arbitration fairness: req0 and req1 valid continuously with distinct operands → accepted ids 0,1,0,1; each response matches its own operands; readies never both high.
5. Backpressure: hold resp_ready=0 for 3 cycles in DONE → Sum, Cout, Ovf and id stable; no req_ready; on resp_ready=1, IDLE next cycle.
6. Reset mid-operation: assert rst two cycles into RUN → busy, resp_valid and readies fall to 0 immediately (asynchronous). After release, req1 alone is accepted next cycle; no stale response appears.
